// File: rtl/vga_sync_gen_if.sv
// Video output bundle of vga_sync_gen: pattern select in, sync/blank/RGB/coordinates out.
interface vga_sync_gen_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
);
  logic [1:0]    MODE;
  logic          VGA_HS;
  logic          VGA_VS;
  logic          VGA_BLANK;
  logic          VGA_SYNC;
  logic [9:0]    VGA_R;
  logic [9:0]    VGA_G;
  logic [9:0]    VGA_B;
  logic [XW-1:0] PIX_X;
  logic [YW-1:0] PIX_Y;
  logic          FRAME_START;

  modport master (
    input  MODE,
    output VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B,
           PIX_X, PIX_Y, FRAME_START
  );

  modport slave (
    output MODE,
    input  VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B,
           PIX_X, PIX_Y, FRAME_START
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator with four frame-synchronous test patterns.
// Counters hold the pixel being generated; every output is registered one cycle later.
module vga_sync_gen #(
  parameter int unsigned HDISP  = 640,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 16,
  parameter int unsigned HPULSE = 96,
  parameter int unsigned HBP    = 48,
  parameter int unsigned VFP    = 10,
  parameter int unsigned VPULSE = 2,
  parameter int unsigned VBP    = 33,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0
) (
  input  logic             CLK,
  input  logic             rst_async,
  vga_sync_gen_if.master   vga
);
  localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int unsigned XW     = $clog2(HTOTAL);
  localparam int unsigned YW     = $clog2(VTOTAL);
  localparam int unsigned BARW   = HDISP / 8;
  localparam int unsigned BW     = (BARW > 1) ? $clog2(BARW) : 1;

  logic [XW-1:0] h_cnt, h_nxt;
  logic [YW-1:0] v_cnt, v_nxt;
  logic [1:0]    mode_q, mode_c;
  logic [BW-1:0] bar_px, bar_px_nxt;
  logic [2:0]    bar_idx, bar_idx_nxt;
  logic          h_last, v_last, at_origin, visible;
  logic          hs_c, vs_c;
  logic [9:0]    r_c, g_c, b_c;

  logic          hs_q, vs_q, blank_q, fs_q;
  logic [9:0]    r_q, g_q, b_q;
  logic [XW-1:0] px_q;
  logic [YW-1:0] py_q;

  // Next counter state and the colour/sync of the pixel at (h_cnt, v_cnt)
  always_comb begin
    h_last    = (h_cnt == XW'(HTOTAL - 1));
    v_last    = (v_cnt == YW'(VTOTAL - 1));
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    // The first pixel of a frame already uses the newly sampled mode
    mode_c    = at_origin ? vga.MODE : mode_q;

    h_nxt = h_last ? '0 : h_cnt + XW'(1);
    v_nxt = v_cnt;
    if (h_last) v_nxt = v_last ? '0 : v_cnt + YW'(1);

    // Bar position tracked incrementally so no divider is needed
    bar_px_nxt  = bar_px + BW'(1);
    bar_idx_nxt = bar_idx;
    if (h_last) begin
      bar_px_nxt  = '0;
      bar_idx_nxt = '0;
    end else if (bar_px == BW'(BARW - 1)) begin
      bar_px_nxt  = '0;
      bar_idx_nxt = bar_idx + 3'd1;
    end

    visible = (32'(h_cnt) < HDISP) && (32'(v_cnt) < VDISP);
    hs_c = ((32'(h_cnt) >= HDISP + HFP) && (32'(h_cnt) < HDISP + HFP + HPULSE))
           ? HS_POL : ~HS_POL;
    vs_c = ((32'(v_cnt) >= VDISP + VFP) && (32'(v_cnt) < VDISP + VFP + VPULSE))
           ? VS_POL : ~VS_POL;

    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (visible) begin
      case (mode_c)
        2'd0: begin
          if (((6'(h_cnt) & 6'h0F) == 6'h00) || ((6'(v_cnt) & 6'h0F) == 6'h00)) begin
            r_c = 10'h3FF;
            g_c = 10'h3FF;
            b_c = 10'h3FF;
          end
        end
        2'd1: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          r_c = {10{~bar_idx[1]}};
          g_c = {10{~bar_idx[2]}};
          b_c = {10{~bar_idx[0]}};
        end
        2'd2: begin
          if (((6'(h_cnt) ^ 6'(v_cnt)) & 6'h20) != 6'h00) begin
            r_c = 10'h3FF;
            g_c = 10'h3FF;
            b_c = 10'h3FF;
          end
        end
        default: begin
          r_c = 10'(h_cnt);
          g_c = 10'(h_cnt);
          b_c = 10'(h_cnt);
        end
      endcase
    end
  end

  // Counter, mode and output registers
  always_ff @(posedge CLK or posedge rst_async) begin
    if (rst_async) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      mode_q  <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      mode_q  <= mode_c;
      bar_px  <= bar_px_nxt;
      bar_idx <= bar_idx_nxt;
      hs_q    <= hs_c;
      vs_q    <= vs_c;
      blank_q <= visible;
      fs_q    <= at_origin;
      r_q     <= r_c;
      g_q     <= g_c;
      b_q     <= b_c;
      px_q    <= h_cnt;
      py_q    <= v_cnt;
    end
  end

  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK   = blank_q;
  assign vga.VGA_SYNC    = 1'b0;
  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;
  assign vga.PIX_X       = px_q;
  assign vga.PIX_Y       = py_q;
  assign vga.FRAME_START = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced 80x47 raster; expected pixels come from a
// coordinate-based model of the video rules, tracked by a position counter.
module tb_vga_sync_gen;
  localparam int unsigned HD = 64, HF = 4, HP = 8, HB = 4;
  localparam int unsigned VD = 40, VF = 2, VP = 3, VB = 2;
  localparam int unsigned HT = HD + HF + HP + HB;
  localparam int unsigned VT = VD + VF + VP + VB;
  localparam int FRAME = int'(HT * VT);
  localparam int unsigned XW = $clog2(HT);
  localparam int unsigned YW = $clog2(VT);
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          blank;
    logic          fs;
    logic [9:0]    r;
    logic [9:0]    g;
    logic [9:0]    b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  logic CLK;
  logic rst_async;
  vga_sync_gen_if #(.XW(XW), .YW(YW)) vif ();

  vga_sync_gen #(
    .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .CLK(CLK),
    .rst_async(rst_async),
    .vga(vif)
  );

  pix_t act;
  assign act = {vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK, vif.FRAME_START,
                vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.PIX_X, vif.PIX_Y};

  int n_cmp = 0;
  int n_bad = 0;
  int n_pos = -1;       // raster index of the pixel currently on the outputs
  int cyc   = 0;
  logic [1:0] frame_mode = 2'd0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic pix_t model(int n, logic [1:0] m);
    pix_t e;
    int x, y;
    bit on;
    logic [2:0] c;
    e = '0;
    e.hs = ~HS_POL;
    e.vs = ~VS_POL;
    if (n < 0) return e;
    x = n % int'(HT);
    y = (n / int'(HT)) % int'(VT);
    e.x  = XW'(x);
    e.y  = YW'(y);
    e.fs = (x == 0) && (y == 0);
    if (x >= int'(HD + HF) && x < int'(HD + HF + HP)) e.hs = HS_POL;
    if (y >= int'(VD + VF) && y < int'(VD + VF + VP)) e.vs = VS_POL;
    if (x < int'(HD) && y < int'(VD)) begin
      e.blank = 1'b1;
      case (m)
        2'd0: begin
          on = (x % 16 == 0) || (y % 16 == 0);
          e.r = on ? 10'h3FF : 10'h0; e.g = e.r; e.b = e.r;
        end
        2'd1: begin
          c = BAR_RGB[x / int'(HD / 8)];
          e.r = {10{c[2]}}; e.g = {10{c[1]}}; e.b = {10{c[0]}};
        end
        2'd2: begin
          on = ((x / 32) % 2) != ((y / 32) % 2);
          e.r = on ? 10'h3FF : 10'h0; e.g = e.r; e.b = e.r;
        end
        default: begin
          e.r = 10'(x % 1024); e.g = e.r; e.b = e.r;
        end
      endcase
    end
    return e;
  endfunction

  // Advance one clock and move the model position; returns #1 after the edge
  task automatic step();
    @(posedge CLK);
    cyc++;
    if (!rst_async) begin
      n_pos++;
      if (n_pos % FRAME == 0) frame_mode = vif.MODE;
    end
    #1;
  endtask

  task automatic test_reset();
    pix_t e;
    rst_async = 1'b1;
    vif.MODE  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = model(-1, 2'd0);
      n_cmp++;
      if (act !== e || vif.VGA_SYNC !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold: got %h sync %b, want %h sync 0", act, vif.VGA_SYNC, e);
      end
    end
    rst_async = 1'b0;
    step();
    e = model(n_pos, frame_mode);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL first_pixel: got %h want %h", act, e);
    end
    n_cmp++;
    if (vif.FRAME_START !== 1'b1 || vif.VGA_R !== 10'h3FF || vif.PIX_X !== '0 || vif.PIX_Y !== '0) begin
      n_bad++;
      $display("FAIL first_pixel_fields: fs %b r %h x %0d y %0d, want fs 1 r 3ff x 0 y 0",
               vif.FRAME_START, vif.VGA_R, vif.PIX_X, vif.PIX_Y);
    end
  endtask

  task automatic test_line_timing();
    pix_t e;
    int blank_n = 0, hs_n = 0, hs_first = -1;
    for (int i = 0; i < 3 * int'(HT); i++) begin
      step();
      e = model(n_pos, frame_mode);
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL line_pixel @%0d: got %h want %h", n_pos, act, e);
      end
      if (n_pos / int'(HT) == 1) begin
        if (vif.VGA_BLANK === 1'b1) blank_n++;
        if (vif.VGA_HS === HS_POL) begin
          hs_n++;
          if (hs_first < 0) hs_first = n_pos % int'(HT);
        end
      end
    end
    n_cmp++;
    if (blank_n != int'(HD) || hs_n != int'(HP) || hs_first != int'(HD + HF)) begin
      n_bad++;
      $display("FAIL line_timing: blank %0d hs %0d hs_start %0d, want %0d %0d %0d",
               blank_n, hs_n, hs_first, HD, HP, HD + HF);
    end
  endtask

  task automatic test_frame_timing();
    pix_t e;
    int vs_n = 0, vs_first = -1, fs_n = 0, fs_at = -1;
    while (n_pos < FRAME + 5) begin
      step();
      e = model(n_pos, frame_mode);
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL frame_pixel @%0d: got %h want %h", n_pos, act, e);
      end
      if (n_pos < FRAME && vif.VGA_VS === VS_POL) begin
        vs_n++;
        if (vs_first < 0) vs_first = n_pos;
      end
      if (vif.FRAME_START === 1'b1) begin
        fs_n++;
        fs_at = n_pos;
      end
      if (n_pos == 1000) vif.MODE = 2'd3;
    end
    n_cmp++;
    if (vs_n != int'(VP * HT) || vs_first != int'((VD + VF) * HT) || fs_n != 1 || fs_at != FRAME) begin
      n_bad++;
      $display("FAIL frame_timing: vs %0d from %0d fs %0d at %0d, want %0d from %0d fs 1 at %0d",
               vs_n, vs_first, fs_n, fs_at, VP * HT, (VD + VF) * HT, FRAME);
    end
  endtask

  task automatic test_bars();
    pix_t e;
    vif.MODE = 2'd1;
    while (n_pos < 2 * FRAME + 10 * int'(HT)) begin
      step();
      e = model(n_pos, frame_mode);
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL bars_pixel @%0d: got %h want %h", n_pos, act, e);
      end
      if (n_pos == 2 * FRAME + 8) begin
        n_cmp++;
        if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} !== {10'h3FF, 10'h3FF, 10'h000}) begin
          n_bad++;
          $display("FAIL bars_yellow: got %h %h %h want 3ff 3ff 0", vif.VGA_R, vif.VGA_G, vif.VGA_B);
        end
      end
      if (n_pos == 2 * FRAME + int'(HD)) begin
        n_cmp++;
        if ({vif.VGA_BLANK, vif.VGA_R, vif.VGA_G, vif.VGA_B} !== 31'h0) begin
          n_bad++;
          $display("FAIL bars_blanking: blank %b rgb %h %h %h want 0", vif.VGA_BLANK, vif.VGA_R, vif.VGA_G, vif.VGA_B);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    pix_t e;
    vif.MODE = 2'd2;
    while (n_pos < 3 * FRAME + 33 * int'(HT)) begin
      step();
      e = model(n_pos, frame_mode);
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL switch_pixel @%0d: got %h want %h", n_pos, act, e);
      end
      if (n_pos == 2 * FRAME + 39 * int'(HT) + 8 || n_pos == 3 * FRAME + 32 ||
          n_pos == 3 * FRAME + 32 * int'(HT) + 32) begin
        n_cmp++;
        if (n_pos == 3 * FRAME + 32 && vif.VGA_G !== 10'h3FF) begin
          n_bad++;
          $display("FAIL checker_32_0: got g %h want 3ff", vif.VGA_G);
        end else if (n_pos == 3 * FRAME + 32 * int'(HT) + 32 && vif.VGA_G !== 10'h000) begin
          n_bad++;
          $display("FAIL checker_32_32: got g %h want 0", vif.VGA_G);
        end else if (n_pos == 2 * FRAME + 39 * int'(HT) + 8 && vif.VGA_B !== 10'h000) begin
          n_bad++;
          $display("FAIL bars_last_line: got b %h want 0", vif.VGA_B);
        end
      end
    end
  endtask

  task automatic test_random_modes();
    pix_t e;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      e = model(n_pos, frame_mode);
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL random_pixel @%0d mode %0d: got %h want %h", n_pos, frame_mode, act, e);
      end
      if ($urandom_range(0, 499) == 0) vif.MODE = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_midframe();
    pix_t e;
    int fs_n = 0, fs_c0 = -1, fs_c1 = -1, guard = 0;
    while (n_pos % FRAME != 20 * int'(HT) + 30 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    #2 rst_async = 1'b1;
    #1;
    e = model(-1, 2'd0);
    n_cmp++;
    if (act !== e || vif.VGA_SYNC !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", act, e);
    end
    n_pos = -1;
    step();
    step();
    vif.MODE  = 2'($urandom_range(0, 3));
    rst_async = 1'b0;
    for (int i = 0; i < FRAME + 20; i++) begin
      step();
      e = model(n_pos, frame_mode);
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL restart_pixel @%0d: got %h want %h", n_pos, act, e);
      end
      if (vif.FRAME_START === 1'b1) begin
        fs_n++;
        if (fs_c0 < 0) fs_c0 = i; else fs_c1 = i;
      end
    end
    n_cmp++;
    if (fs_n != 2 || fs_c0 != 0 || fs_c1 - fs_c0 != FRAME) begin
      n_bad++;
      $display("FAIL restart_period: fs %0d first %0d period %0d, want 2 0 %0d",
               fs_n, fs_c0, fs_c1 - fs_c0, FRAME);
    end
  endtask

  initial begin
    rst_async = 1'b1;
    vif.MODE  = 2'd0;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_bars();
    test_mode_switch();
    test_random_modes();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
